gate_seq: RTL
=============

Name: gate_seq

Overview:
- Sequencer that exercises a 2-input combinational gate (default: OR) with all four input vectors in order 00, 01, 10, 11.
- Holds each vector for STEP clocks, samples the gate output on the last clock of each vector and checks it against a programmable truth table.
- Reports busy/done/pass status and an error count.
- Sits between a bench or top-level controller and the gate under test; replaces hand-written delay-based stimulus with a synthesizable controller.

Parameters:
- STEP, 4, clocks each input vector is held; legal range 1..255.
- EXP, 4'b1110, expected gate output indexed by {a,b}; bit0 is for vector 00 and bit3 is for vector 11; the default is OR.
- CW, 8, width of the internal hold counter; must satisfy 2^CW >= STEP.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-clock request to run one sweep; ignored while busy=1.
- a  output  1  gate input A.
- b  output  1  gate input B.
- c  input  1  gate output under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-clock pulse when a sweep completes.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_cnt  output  3  mismatch count of the current or last sweep (0..4).
- vec_idx  output  2  index of the vector being driven, equal to {a,b}.

Behaviour:
- Reset (rst_n=0, asynchronous, at any time including mid-sweep):
  - a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, vec_idx=0.
  - FSM goes to IDLE and the counter clears.
  - Leaving reset does not start a sweep.
- States are IDLE, DRIVE and FIN.
- IDLE:
  - a=b=0.
  - On start=1 at a rising edge: go to DRIVE, busy=1, vec_idx=0, cnt=0, err_cnt=0, pass=0.
- DRIVE:
  - {a,b}=vec_idx, driven from registers (glitch-free).
  - cnt increments each clock from 0 to STEP-1.
  - At the edge where cnt==STEP-1:
    - If c != EXP[vec_idx], err_cnt increments.
    - cnt clears.
    - If vec_idx<3, vec_idx increments and the FSM stays in DRIVE.
    - If vec_idx==3, go to FIN.
  - c is compared only at that edge; any other c activity is ignored (the gate has settled).
- FIN (exactly one cycle):
  - busy=0, done=1, a=b=0, vec_idx=0.
  - pass=(err_cnt==0).
  - Next state is IDLE.
  - A start arriving in FIN is ignored.
- Latency:
  - A start sampled at edge E gives busy=1 after E.
  - done=1 in the cycle after edge E+4*STEP.
  - Total busy time is 4*STEP cycles.
- Hold values:
  - pass and err_cnt keep their values after done until the next accepted start.
  - done is never high for more than one cycle.
- STEP=1: each vector is driven for one cycle and sampled at the end of that cycle.
- Boundary cases:
  - start held high continuously: a new sweep begins on the first IDLE cycle after FIN, so there is one idle cycle between sweeps.
  - err_cnt reaches at most 4, so no wrap occurs.

Optional Feature:
- Macro: GSEQ_CAPTURE_EN.
- Defined:
  - Adds output port cap[3:0], which holds the c value sampled for each vector; cap[vec_idx] is written at the sample edge.
  - cap clears to 0 on reset and on an accepted start.
  - cap holds its value after done.
  - In a passing sweep cap==EXP.
- Undefined: no cap port and no capture registers; all other behaviour is identical.

Test Plan:
- Reset mid-sweep:
  - Stimulus: assert rst_n=0 during vector 10.
  - Response: immediately a=b=0, busy=0, err_cnt=0, FSM in IDLE.
  - After rst_n=1 with no start, the block stays idle.
- Correct OR gate, STEP=4:
  - Stimulus: one start pulse.
  - Response: {a,b} sequence 00,01,10,11 with 4 clocks each; done pulses 16 clocks after busy rises; pass=1, err_cnt=0; cap=4'b1110 when GSEQ_CAPTURE_EN is defined.
- Faulty gate, c tied to 0:
  - Stimulus: one sweep.
  - Response: err_cnt=3, pass=0; cap=4'b0000 when GSEQ_CAPTURE_EN is defined.
- AND gate with EXP=4'b1000:
  - Stimulus: one sweep.
  - Response: pass=1.
  - The same AND gate with default EXP gives err_cnt=2.
- start pulsed during busy, and start held high:
  - Stimulus: a start pulse while busy=1.
  - Response: the pulse is ignored and the sweep length is unchanged.
  - Stimulus: start held high continuously.
  - Response: back-to-back sweeps with exactly one IDLE cycle between the done pulse and the next busy rise.
- STEP=1:
  - Stimulus: one sweep.
  - Response: each vector is driven for 1 cycle; done arrives 4 cycles after busy rises; the results are correct.

Source files
------------

// File: rtl/gate_seq_if.sv
// Bundles the controller-facing signals of gate_seq. The gate_seq side uses the master modport.
// GSEQ_CAPTURE_EN adds the cap capture bus.
interface gate_seq_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] vec_idx;
`ifdef GSEQ_CAPTURE_EN
    logic [3:0] cap;
`endif

    modport master (
        input  start,
        input  c,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output vec_idx
`ifdef GSEQ_CAPTURE_EN
        , output cap
`endif
    );

    modport slave (
        output start,
        output c,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  vec_idx
`ifdef GSEQ_CAPTURE_EN
        , input cap
`endif
    );
endinterface

// File: rtl/gate_seq.sv
// Purpose: sweeps a 2-input gate through 00,01,10,11 and checks c against truth table EXP.
// Latency: start at edge E -> busy after E, done pulse in the cycle after edge E+4*STEP.
// Backpressure: none; start is ignored while busy or in FIN. GSEQ_CAPTURE_EN adds cap.
module gate_seq #(
    parameter int          STEP = 4,
    parameter logic [3:0]  EXP  = 4'b1110,
    parameter int          CW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    gate_seq_if.master    io
);
    typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;

    localparam logic [CW-1:0] LAST = CW'(STEP - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    vec;
    logic [2:0]    err;
    logic          a_q;
    logic          b_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic          miss;
    logic [2:0]    err_nxt;
    logic [1:0]    vec_nxt;
`ifdef GSEQ_CAPTURE_EN
    logic [3:0]    cap_q;
`endif

    // Only meaningful at the sample edge; c is ignored everywhere else.
    assign miss    = (io.c != EXP[vec]);
    assign err_nxt = err + {2'b00, miss};
    assign vec_nxt = vec + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            vec    <= 2'd0;
            err    <= 3'd0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
`ifdef GSEQ_CAPTURE_EN
            cap_q  <= 4'b0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    a_q    <= 1'b0;
                    b_q    <= 1'b0;
                    if (io.start) begin
                        state  <= DRIVE;
                        busy_q <= 1'b1;
                        vec    <= 2'd0;
                        cnt    <= '0;
                        err    <= 3'd0;
                        pass_q <= 1'b0;
`ifdef GSEQ_CAPTURE_EN
                        cap_q  <= 4'b0000;
`endif
                    end
                end
                DRIVE: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        err <= err_nxt;
`ifdef GSEQ_CAPTURE_EN
                        cap_q[vec] <= io.c;
`endif
                        if (vec != 2'd3) begin
                            vec <= vec_nxt;
                            a_q <= vec_nxt[1];
                            b_q <= vec_nxt[0];
                        end else begin
                            // Pass uses the count including this last sample.
                            state  <= FIN;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_nxt == 3'd0);
                            vec    <= 2'd0;
                            a_q    <= 1'b0;
                            b_q    <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.a       = a_q;
    assign io.b       = b_q;
    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.pass    = pass_q;
    assign io.err_cnt = err;
    assign io.vec_idx = vec;
`ifdef GSEQ_CAPTURE_EN
    assign io.cap     = cap_q;
`endif
endmodule
